// File: rtl/click_sync_rx.sv
// Receiving end of a 2-phase bundled-data click channel feeding a clocked valid/ready stream.
// Define CLICK_RX_STATS_EN to add the 16-bit rx_count accepted-token counter port.
module click_sync_rx #(
   parameter int DATA_WIDTH  = 7,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_req,
   output logic                in_ack,
   input  logic [DATA_WIDTH:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_WIDTH:0] out_data
`ifdef CLICK_RX_STATS_EN
   ,
   output logic [15:0]         rx_count
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ack_q, ack_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic                   valid_q, valid_d;
   logic [DATA_WIDTH:0]    head_q, head_d;
   logic [DATA_WIDTH:0]    mem_q [DEPTH];
   logic                   req_s, pending_s, push_s, pop_s;

   // Handshake decode, pointer/count next-state and the registered head entry
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], in_req};
      req_s     = sync_q[SYNC_STAGES-1];
      pending_s = req_s ^ ack_q;
      pop_s     = valid_q & out_ready;
      push_s    = pending_s & ((count_q != FULL_CNT) | pop_s);
      ack_d     = ack_q ^ push_s;
      wr_ptr_d  = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      // A push landing at the new read slot means the queue was empty after any pop
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = in_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Synchroniser, handshake state, pointers and stream output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         sync_q   <= sync_d;
         ack_q    <= ack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   // FIFO storage; in_data is only sampled on the push edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign in_ack    = ack_q;
   assign out_valid = valid_q;
   assign out_data  = head_q;

`ifdef CLICK_RX_STATS_EN
   logic [15:0] rx_count_q;

   // Accepted-token counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_count_q <= 16'd0;
      end else if (push_s) begin
         rx_count_q <= rx_count_q + 16'd1;
      end
   end

   assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_click_sync_rx.sv
// Self-checking bench for click_sync_rx: vector table, scoreboard-checked stream,
// back-pressure, full-with-pop and mid-stream reset sequences.
module tb_click_sync_rx;

   localparam int DW    = 7;
   localparam int DEPTH = 4;
   localparam int SS    = 2;

   typedef struct {
      logic [DW:0] data;
      logic        exp_ack;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_req;
   logic        in_ack;
   logic [DW:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [DW:0] out_data;
`ifdef CLICK_RX_STATS_EN
   logic [15:0] rx_count;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          sent  = 0;
   logic        done  = 1'b0;
   logic [DW:0] sb [$];
   vec_t        vecs [6];

   click_sync_rx #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_req   (in_req),
      .in_ack   (in_ack),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef CLICK_RX_STATS_EN
      ,
      .rx_count (rx_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted stream beat must match the oldest token sent
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_extra: got %0h, expected no token (t=%0t)", out_data, $time);
         end else begin
            check("stream_data", 32'(out_data), 32'(sb.pop_front()));
         end
      end
   end

   // Sender: wait for the previous token's ack, then present data and toggle req
   task automatic send(input logic [DW:0] d);
      int n = 0;
      @(posedge clk); #1;
      while (in_ack !== in_req && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (in_ack !== in_req) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got ack=%0b, expected ack=%0b", in_ack, in_req);
      end
      in_data = d;
      in_req  = ~in_req;
      sb.push_back(d);
      sent++;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (in_ack !== in_req && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(in_ack), 32'(in_req));
   endtask

   task automatic drain(input string name);
      int n = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, exp_ack: 1'b1};
      vecs[1] = '{data: 8'h3C, exp_ack: 1'b0};
      vecs[2] = '{data: 8'hFF, exp_ack: 1'b1};
      vecs[3] = '{data: 8'h00, exp_ack: 1'b0};
      vecs[4] = '{data: 8'h81, exp_ack: 1'b1};
      vecs[5] = '{data: 8'h5A, exp_ack: 1'b0};

      rst_n     = 1'b0;
      in_req    = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      #12;
      check("reset_ack", 32'(in_ack), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_data", 32'(out_data), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Single tokens with ready high: ack latency and one-cycle valid pulse
      for (int i = 0; i < 6; i++) begin
         logic found;
         found = 1'b0;
         send(vecs[i].data);
         for (int k = 0; k <= SS + 2 && !found; k++) begin
            @(negedge clk);
            if (in_ack === vecs[i].exp_ack) found = 1'b1;
         end
         check("ack_latency", 32'(in_ack), 32'(vecs[i].exp_ack));
         check("valid_pulse_hi", 32'(out_valid), 32'd1);
         check("head_data", 32'(out_data), 32'(vecs[i].data));
         @(negedge clk);
         check("valid_pulse_lo", 32'(out_valid), 32'd0);
      end

      // Back-pressure: five tokens into a four-entry FIFO
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send((DW+1)'(i));
      repeat (8) @(negedge clk);
      check("bp_ack_after_4", 32'(in_ack), 32'd0);
      check("bp_5th_pending", 32'(in_req), 32'd1);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_head", 32'(out_data), 32'h01);

      // Full with a single-cycle pop: push and pop on one edge
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("full_pop_ack", 32'(in_ack), 32'd1);
      check("full_pop_head", 32'(out_data), 32'h02);
      check("full_pop_valid", 32'(out_valid), 32'd1);
      send(8'h06);
      repeat (6) @(negedge clk);
      check("full_hold_ack", 32'(in_ack), 32'd1);
      check("stall_stable", 32'(out_data), 32'h02);
      drain("bp_drain");
      wait_idle("bp_idle");

      // Mid-stream reset with two tokens buffered
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h11);
      send(8'h22);
      wait_idle("rst_pre_idle");
      repeat (2) @(negedge clk);
      check("rst_pre_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #3;
      rst_n  = 1'b0;
      in_req = 1'b0;
      #1;
      check("rst_async_ack", 32'(in_ack), 32'd0);
      check("rst_async_valid", 32'(out_valid), 32'd0);
      sb.delete();
      sent = 0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
      check("rst_ack_idle", 32'(in_ack), 32'd0);
      send(8'h77);
      drain("rst_post_drain");

      // Random streaming with random consumer readiness
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 64; i++) send((DW+1)'($urandom));
            done = 1'b1;
         end
         begin
            int c = 0;
            while (!(done && sb.size() == 0) && c < 4000) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 1) == 1);
               c++;
            end
         end
      join
      check("stream_drained", 32'(sb.size()), 32'd0);
      wait_idle("stream_idle");

`ifdef CLICK_RX_STATS_EN
      check("rx_count", 32'(rx_count), 32'(sent));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
